div_err_monitor: RTL

Sequential error-metrics stage that sits directly downstream of the 16/8 approximate array divider during power/MSE characterization. It accepts one operand pair together with the approximate divider's quotient and remainder, and recomputes the exact result with a bit-serial restoring divider. It then accumulates squared quotient error, mismatch count and maximum absolute error for heuristic scoring. Operand pairs outside the array's valid range are counted and discarded.

---
 rtl/div_err_monitor.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/div_err_monitor.sv
// Error-metrics stage behind the 16/8 approximate divider: recomputes the exact result bit-serially and accumulates error statistics.
// Optional remainder checking is enabled by defining DIV_ERR_MON_REM_CHECK_EN.
module div_err_monitor #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      n_in,
    input  logic [7:0]       d_in,
    input  logic [7:0]       q_apx,
    input  logic [7:0]       r_apx,
    output logic             res_valid,
    output logic [8:0]       last_err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [ACC_W-1:0] sq_err_sum,
    output logic [ACC_W-1:0] rem_sq_err_sum,
    output logic [7:0]       max_abs_err
);

    // state | meaning
    // IDLE  | waiting for a sample; out-of-range operands are counted and dropped here
    // DIV   | one restoring-division step per cycle, quotient MSB first
    // ACC   | fold the finished sample into the statistics and pulse res_valid
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ACC
    } state_t;

    state_t           state_q;
    logic [15:0]      n_q;
    logic [7:0]       d_q;
    logic [7:0]       qa_q;
    logic [7:0]       rem_q;
    logic [7:0]       quo_q;
    logic [2:0]       idx_q;

    logic             res_valid_q;
    logic [8:0]       last_err_q;
    logic [CNT_W-1:0] sample_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] skip_cnt_q;
    logic [ACC_W-1:0] sq_sum_q;
    logic [7:0]       max_q;

    logic             bad_operands;
    logic [8:0]       step_t;
    logic             step_ge;
    logic [7:0]       step_rem;
    logic [8:0]       q_err;
    logic [7:0]       q_abs;
    logic [15:0]      q_sq;
    logic [ACC_W:0]   sq_sum_x;
    logic [ACC_W-1:0] sq_sum_d;
    logic [7:0]       max_d;
    logic             q_mismatch;
    logic             mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        bad_operands = (d_in == 8'd0) || (n_in[15:8] >= d_in);

        // Partial remainder stays below d, so the 9-bit trial fits and t-d fits in 8 bits.
        step_t   = {rem_q, n_q[idx_q]};
        step_ge  = (step_t >= {1'b0, d_q});
        step_rem = step_ge ? (step_t[7:0] - d_q) : step_t[7:0];

        q_err    = {1'b0, quo_q} - {1'b0, qa_q};
        q_abs    = q_err[8] ? (8'd0 - q_err[7:0]) : q_err[7:0];
        q_sq     = {8'd0, q_abs} * {8'd0, q_abs};
        sq_sum_x = {1'b0, sq_sum_q} + {{(ACC_W-15){1'b0}}, q_sq};
        sq_sum_d = sq_sum_x[ACC_W] ? {ACC_W{1'b1}} : sq_sum_x[ACC_W-1:0];
        max_d    = (q_abs > max_q) ? q_abs : max_q;
        q_mismatch = (quo_q != qa_q);
    end

`ifdef DIV_ERR_MON_REM_CHECK_EN
    logic [7:0]       ra_q;
    logic [ACC_W-1:0] rsq_sum_q;
    logic [8:0]       r_err;
    logic [7:0]       r_abs;
    logic [15:0]      r_sq;
    logic [ACC_W:0]   rsq_sum_x;
    logic [ACC_W-1:0] rsq_sum_d;

    always_comb begin
        r_err     = {1'b0, rem_q} - {1'b0, ra_q};
        r_abs     = r_err[8] ? (8'd0 - r_err[7:0]) : r_err[7:0];
        r_sq      = {8'd0, r_abs} * {8'd0, r_abs};
        rsq_sum_x = {1'b0, rsq_sum_q} + {{(ACC_W-15){1'b0}}, r_sq};
        rsq_sum_d = rsq_sum_x[ACC_W] ? {ACC_W{1'b1}} : rsq_sum_x[ACC_W-1:0];
        mismatch  = q_mismatch || (rem_q != ra_q);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ra_q      <= 8'd0;
            rsq_sum_q <= '0;
        end else begin
            if (state_q == S_IDLE && in_valid && in_ready && !bad_operands) begin
                ra_q <= r_apx;
            end
            if (state_q == S_ACC) begin
                rsq_sum_q <= rsq_sum_d;
            end
        end
    end

    assign rem_sq_err_sum = rsq_sum_q;
`else
    logic unused_r_apx;

    always_comb begin
        mismatch = q_mismatch;
    end

    assign unused_r_apx   = ^r_apx;
    assign rem_sq_err_sum = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= S_IDLE;
            n_q          <= 16'd0;
            d_q          <= 8'd0;
            qa_q         <= 8'd0;
            rem_q        <= 8'd0;
            quo_q        <= 8'd0;
            idx_q        <= 3'd0;
            res_valid_q  <= 1'b0;
            last_err_q   <= 9'd0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            sq_sum_q     <= '0;
            max_q        <= 8'd0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (bad_operands) begin
                            skip_cnt_q <= sat_inc(skip_cnt_q);
                        end else begin
                            n_q     <= n_in;
                            d_q     <= d_in;
                            qa_q    <= q_apx;
                            rem_q   <= n_in[15:8];
                            quo_q   <= 8'd0;
                            idx_q   <= 3'd7;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[6:0], step_ge};
                    if (idx_q == 3'd0) begin
                        state_q <= S_ACC;
                    end else begin
                        idx_q <= idx_q - 3'd1;
                    end
                end
                S_ACC: begin
                    sq_sum_q     <= sq_sum_d;
                    sample_cnt_q <= sat_inc(sample_cnt_q);
                    if (mismatch) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end
                    max_q       <= max_d;
                    last_err_q  <= q_err;
                    res_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE) && !clear && !rst;
    assign res_valid   = res_valid_q;
    assign last_err    = last_err_q;
    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign skip_cnt    = skip_cnt_q;
    assign sq_err_sum  = sq_sum_q;
    assign max_abs_err = max_q;

endmodule
